// File: rtl/mor1kx_dpram_pkg.sv
// rtl/mor1kx_dpram_pkg.sv - shared types and helpers for the byte-enable dual-port RAM
package mor1kx_dpram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dpram_state_e;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mor1kx_dpram_clear_seq.sv
// rtl/mor1kx_dpram_clear_seq.sv - post-reset zero-fill sequencer driving the RAM write port
module mor1kx_dpram_clear_seq
    import mor1kx_dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    dpram_state_e          state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt <= '0;
            busy    <= (CLEAR_ON_RESET != 0);
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // Last address is written on this edge; hand over in the same edge.
                    if (clr_cnt == '1) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/mor1kx_dpram_be.sv
// rtl/mor1kx_dpram_be.sv - simple dual-port RAM with byte enables, bypass, output reg and clear
module mor1kx_dpram_be
    import mor1kx_dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int ENABLE_BYPASS  = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    busy
);

    localparam int BE_W  = be_width(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("mor1kx_dpram_be: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_too_wide
        $error("mor1kx_dpram_be: DATA_WIDTH exceeds byte_merge width");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc_we;
    logic                  acc_re;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    mor1kx_dpram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign acc_we = !busy && we && (be != '0);
    assign acc_re = !busy && re;

    // The merged write word doubles as the bypass value for a same-address read.
    always_comb begin
        wr_word = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[waddr]),
                                         MAX_DATA_WIDTH'(din),
                                         MAX_BE_WIDTH'(be)));
        rd_word = mem[raddr];
        if ((ENABLE_BYPASS != 0) && acc_we && (waddr == raddr)) begin
            rd_word = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (acc_we) begin
                mem[waddr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= acc_re;
            if (acc_re) begin
                rd_data <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= rd_valid;
                if (rd_valid) begin
                    dout <= rd_data;
                end
            end
        end
    end else begin : g_no_out_reg
        assign dout       = rd_data;
        assign dout_valid = rd_valid;
    end

    logic unused_be_w;
    assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_mor1kx_dpram_be.sv
// tb/tb_mor1kx_dpram_be.sv - directed checks of old-data, bypass and output-register RAM builds
module tb_mor1kx_dpram_be;

    logic        clk;
    logic        rst_n;
    logic        re;
    logic [3:0]  raddr;
    logic        we;
    logic [3:0]  waddr;
    logic [3:0]  be;
    logic [31:0] din;

    logic [31:0] dout_a, dout_b, dout_c;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    mor1kx_dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .rst_n(rst_n), .re(re), .raddr(raddr), .we(we), .waddr(waddr), .be(be),
           .din(din), .dout(dout_a), .dout_valid(valid_a), .busy(busy_a));

    mor1kx_dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(1), .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .rst_n(rst_n), .re(re), .raddr(raddr), .we(we), .waddr(waddr), .be(be),
           .din(din), .dout(dout_b), .dout_valid(valid_b), .busy(busy_b));

    mor1kx_dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(0), .OUT_REG(1), .CLEAR_ON_RESET(1))
    dut_c (.clk(clk), .rst_n(rst_n), .re(re), .raddr(raddr), .we(we), .waddr(waddr), .be(be),
           .din(din), .dout(dout_c), .dout_valid(valid_c), .busy(busy_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_clear(input string name);
        int cyc;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cyc++;
            if (busy_a) begin
                check($sformatf("%s_valid_busy_%0d", name, k), {31'b0, valid_a}, 32'd0);
            end else begin
                break;
            end
        end
        check({name, "_len"}, cyc, 32'd16);
        check({name, "_busy_b"}, {31'b0, busy_b}, 32'd0);
        check({name, "_busy_c"}, {31'b0, busy_c}, 32'd0);
    endtask

    typedef struct {
        logic        re;
        logic [3:0]  raddr;
        logic        we;
        logic [3:0]  waddr;
        logic [3:0]  be;
        logic [31:0] din;
        logic        exp_valid;
        logic [31:0] exp_old;
        logic [31:0] exp_byp;
    } vec_t;

    vec_t vecs [14];

    logic        exp_av [6] = '{1, 1, 1, 0, 0, 0};
    logic [31:0] exp_ad [6] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'hC};
    logic        exp_cv [6] = '{0, 1, 1, 1, 0, 0};
    logic [31:0] exp_cd [6] = '{32'h99, 32'hA, 32'hB, 32'hC, 32'hC, 32'hC};

    initial begin
        logic        prev_v;
        logic [31:0] prev_d;

        vecs[0]  = '{1'b0, 4'd0, 1'b1, 4'd5, 4'hF, 32'h11223344, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 4'd0, 1'b1, 4'd5, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, 4'd5, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 32'h11BB33DD, 32'h11BB33DD};
        vecs[3]  = '{1'b1, 4'd7, 1'b1, 4'd7, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 4'd7, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 4'd8, 1'b1, 4'd8, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 4'd8, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 4'd0, 1'b1, 4'd8, 4'hF, 32'h12345678, 1'b0, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 4'd8, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 32'h12345678, 32'h12345678};
        vecs[9]  = '{1'b0, 4'd0, 1'b1, 4'd8, 4'h2, 32'h0,        1'b0, 32'h12345678, 32'h12345678};
        vecs[10] = '{1'b1, 4'd8, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 32'h12340078, 32'h12340078};
        vecs[11] = '{1'b1, 4'd8, 1'b1, 4'd9, 4'hF, 32'h99,       1'b1, 32'h12340078, 32'h12340078};
        vecs[12] = '{1'b1, 4'd9, 1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 32'h99,       32'h99};
        vecs[13] = '{1'b0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 32'h99,       32'h99};

        rst_n = 1'b0; re = 1'b0; raddr = '0; we = 1'b0; waddr = '0; be = '0; din = '0;
        tick();
        tick();
        check("rst_busy_a", {31'b0, busy_a}, 32'd1);
        check("rst_busy_c", {31'b0, busy_c}, 32'd1);
        check("rst_dout_a", dout_a, 32'd0);
        check("rst_dout_c", dout_c, 32'd0);
        check("rst_valid_b", {31'b0, valid_b}, 32'd0);

        // Write and read attempted throughout the clear must be ignored.
        rst_n = 1'b1;
        we = 1'b1; waddr = 4'd3; be = 4'hF; din = 32'hFFFFFFFF;
        re = 1'b1; raddr = 4'd3;
        count_clear("clear");
        we = 1'b0; re = 1'b0;
        tick();
        check("post_clear_valid_a", {31'b0, valid_a}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = 4'(i);
            tick();
            check($sformatf("zero_valid_a_%0d", i), {31'b0, valid_a}, 32'd1);
            check($sformatf("zero_dout_a_%0d", i), dout_a, 32'd0);
            check($sformatf("zero_dout_c_%0d", i), dout_c, 32'd0);
            check($sformatf("zero_valid_c_%0d", i), {31'b0, valid_c}, (i >= 1) ? 32'd1 : 32'd0);
        end

        // The latency-2 build trails the latency-1 expectation by one row.
        prev_v = 1'b1;
        prev_d = 32'h0;
        for (int i = 0; i < 14; i++) begin
            re = vecs[i].re; raddr = vecs[i].raddr;
            we = vecs[i].we; waddr = vecs[i].waddr; be = vecs[i].be; din = vecs[i].din;
            tick();
            check($sformatf("vec%0d_valid_a", i), {31'b0, valid_a}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_dout_a", i), dout_a, vecs[i].exp_old);
            check($sformatf("vec%0d_valid_b", i), {31'b0, valid_b}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_dout_b", i), dout_b, vecs[i].exp_byp);
            check($sformatf("vec%0d_valid_c", i), {31'b0, valid_c}, {31'b0, prev_v});
            check($sformatf("vec%0d_dout_c", i), dout_c, prev_d);
            prev_v = vecs[i].exp_valid;
            prev_d = vecs[i].exp_old;
        end

        re = 1'b0; we = 1'b1; be = 4'hF;
        waddr = 4'd1; din = 32'hA; tick();
        waddr = 4'd2; din = 32'hB; tick();
        waddr = 4'd3; din = 32'hC; tick();
        we = 1'b0;
        for (int t = 0; t < 6; t++) begin
            re = (t < 3); raddr = 4'(t + 1);
            we = (t == 3); waddr = 4'd3; din = 32'h5;
            tick();
            check($sformatf("lat%0d_valid_a", t), {31'b0, valid_a}, {31'b0, exp_av[t]});
            check($sformatf("lat%0d_dout_a", t), dout_a, exp_ad[t]);
            check($sformatf("lat%0d_valid_c", t), {31'b0, valid_c}, {31'b0, exp_cv[t]});
            check($sformatf("lat%0d_dout_c", t), dout_c, exp_cd[t]);
        end
        re = 1'b0; we = 1'b0;

        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        check("midclear_busy_before", {31'b0, busy_a}, 32'd1);
        rst_n = 1'b0; tick();
        check("midclear_busy_a", {31'b0, busy_a}, 32'd1);
        check("midclear_dout_a", dout_a, 32'd0);
        check("midclear_dout_c", dout_c, 32'd0);
        check("midclear_valid_c", {31'b0, valid_c}, 32'd0);
        rst_n = 1'b1;
        count_clear("reclear");

        re = 1'b1; raddr = 4'd8;
        tick();
        re = 1'b0;
        check("reclear_read_valid_a", {31'b0, valid_a}, 32'd1);
        check("reclear_read_dout_a", dout_a, 32'd0);
        tick();
        check("reclear_read_valid_c", {31'b0, valid_c}, 32'd1);
        check("reclear_read_dout_c", dout_c, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
